// File: rtl/display_scan_ctrl_if.sv
// Segment/anode scan bus for display_scan_ctrl: the host side drives enable and load
// data, and the controller side returns the digit drives and status.
interface display_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    en;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    frame_done;
  logic                    busy;

  modport master (
    output en, load, data_in,
    input  an, seg, frame_done, busy
  );

  modport slave (
    input  en, load, data_in,
    output an, seg, frame_done, busy
  );
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered, frame-aligned updates.
// Define DISPLAY_LZ_BLANK_EN to blank leading-zero digits (digit 0 is always shown).
module display_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_CNT  = 80000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  display_scan_ctrl_if.slave bus
);

  localparam int unsigned CntMax    = (REFRESH_CNT > BLANK_CYCLES) ? REFRESH_CNT : BLANK_CYCLES;
  localparam int unsigned CntW      = $clog2(CntMax + 1);
  localparam int unsigned IdxW      = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned BlankLast = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
  localparam int unsigned DataW     = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

  // With no dead-time every slot starts directly in DRIVE.
  localparam state_e StartSt = (BLANK_CYCLES > 0) ? StBlank : StDrive;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic [IdxW-1:0]   idx_q;
  logic [DataW-1:0]  active_q;
  logic [DataW-1:0]  shadow_q;
  logic              pending_q;
  logic              frame_done_q;

  logic              slot_end;
  logic              last_digit;
  logic              frame_edge;
  logic [3:0]        nib [NUM_DIGITS];
  logic              lz_blank;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0:    hex7 = 7'h40;
      4'h1:    hex7 = 7'h79;
      4'h2:    hex7 = 7'h24;
      4'h3:    hex7 = 7'h30;
      4'h4:    hex7 = 7'h19;
      4'h5:    hex7 = 7'h12;
      4'h6:    hex7 = 7'h02;
      4'h7:    hex7 = 7'h78;
      4'h8:    hex7 = 7'h00;
      4'h9:    hex7 = 7'h10;
      4'hA:    hex7 = 7'h08;
      4'hB:    hex7 = 7'h03;
      4'hC:    hex7 = 7'h46;
      4'hD:    hex7 = 7'h21;
      4'hE:    hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  assign slot_end   = (state_q == StDrive) && (cnt_q == CntW'(REFRESH_CNT - 1));
  assign last_digit = (idx_q == IdxW'(NUM_DIGITS - 1));
  assign frame_edge = slot_end && last_digit;

  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      nib[i] = active_q[4*i +: 4];
    end
  end

`ifdef DISPLAY_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] zero_from;

  // zero_from[i]: nibbles i..NUM_DIGITS-1 are all zero.
  always_comb begin
    logic z;
    z = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      z            = z && (nib[i] == 4'h0);
      zero_from[i] = z;
    end
  end

  assign lz_blank = (idx_q != '0) && zero_from[idx_q];
`else
  assign lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.en) begin
            state_q <= StartSt;
            idx_q   <= '0;
            cnt_q   <= '0;
          end
        end
        StBlank: begin
          if (cnt_q == CntW'(BlankLast)) begin
            state_q <= StDrive;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDrive: begin
          if (slot_end) begin
            cnt_q <= '0;
            if (last_digit) begin
              idx_q        <= '0;
              frame_done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
            state_q <= bus.en ? StartSt : StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A load on the boundary edge is newer than anything in the shadow, so it wins.
      if (frame_edge) begin
        if (bus.load) begin
          active_q  <= bus.data_in;
          pending_q <= 1'b0;
        end else if (pending_q) begin
          active_q  <= shadow_q;
          pending_q <= 1'b0;
        end
      end else if (bus.load) begin
        if (state_q == StIdle) begin
          active_q  <= bus.data_in;
          pending_q <= 1'b0;
        end else begin
          shadow_q  <= bus.data_in;
          pending_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    bus.an  = '1;
    bus.seg = 7'h7F;
    if (state_q == StDrive && !lz_blank) begin
      bus.an  = ~(NUM_DIGITS'(1) << idx_q);
      bus.seg = hex7(nib[idx_q]);
    end
  end

  assign bus.frame_done = frame_done_q;
  assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomised and directed bench for display_scan_ctrl; expected outputs come from a
// frame-position model (digit = pos / slot, phase = pos % slot).
module tb_display_scan_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned R = 4;
  localparam int unsigned B = 1;
  localparam int unsigned S = B + R;
  localparam int unsigned F = N * S;

  logic clk = 1'b0;
  logic rst = 1'b0;

  display_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS  (N),
    .REFRESH_CNT (R),
    .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model state
  bit          m_run;
  int          m_pos;
  logic [15:0] m_act;
  logic [15:0] m_sh;
  bit          m_pend;
  bit          m_fd;

  task automatic model_step();
    bit slot_end;
    bit frame_end;
    if (!rst) begin
      m_run = 0; m_pos = 0; m_act = '0; m_sh = '0; m_pend = 0; m_fd = 0;
      return;
    end
    m_fd = 0;
    if (!m_run) begin
      if (bus.load) begin m_act = bus.data_in; m_pend = 0; end
      if (bus.en) begin m_run = 1; m_pos = 0; end
    end else begin
      slot_end  = (m_pos % S) == S - 1;
      frame_end = (m_pos == F - 1);
      if (bus.load) begin
        if (frame_end) begin m_act = bus.data_in; m_pend = 0; end
        else begin m_sh = bus.data_in; m_pend = 1; end
      end else if (frame_end && m_pend) begin
        m_act = m_sh; m_pend = 0;
      end
      m_fd = frame_end;
      if (slot_end) begin
        if (bus.en) m_pos = (m_pos + 1) % F;
        else m_run = 0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check();
    logic [3:0] e_an;
    logic [6:0] e_seg;
    int d;
    e_an  = 4'hF;
    e_seg = 7'h7F;
    if (m_run && (m_pos % S) >= B) begin
      d     = m_pos / S;
      e_an  = ~(4'b0001 << d);
      e_seg = hex_tab[m_act[4*d +: 4]];
`ifdef DISPLAY_LZ_BLANK_EN
      if (d > 0 && (m_act >> (4 * d)) == 16'h0) begin
        e_an  = 4'hF;
        e_seg = 7'h7F;
      end
`endif
    end
    tests++;
    assert (bus.an === e_an) else begin
      fails++; $error("FAIL an t=%0t got %h exp %h", $time, bus.an, e_an);
    end
    tests++;
    assert (bus.seg === e_seg) else begin
      fails++; $error("FAIL seg t=%0t got %h exp %h", $time, bus.seg, e_seg);
    end
    tests++;
    assert (bus.busy === m_run) else begin
      fails++; $error("FAIL busy t=%0t got %b exp %b", $time, bus.busy, m_run);
    end
    tests++;
    assert (bus.frame_done === m_fd) else begin
      fails++; $error("FAIL frame_done t=%0t got %b exp %b", $time, bus.frame_done, m_fd);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      model_step();
      @(posedge clk);
      #1;
      check();
      bus.load = 1'b0;
    end
  endtask

  // Advance until the model sits at frame position p, bounded.
  task automatic run_until(input int p);
    int lim;
    lim = 4 * F;
    while (!(m_run && m_pos == p) && lim > 0) begin
      tick();
      lim--;
    end
    if (lim == 0) begin
      tests++;
      fails++;
      $error("FAIL run_until got pos %0d exp %0d", m_pos, p);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    bus.load    = 1'b1;
    bus.data_in = v;
    tick();
  endtask

  initial begin
    bus.en      = 1'b1;
    bus.load    = 1'b0;
    bus.data_in = '0;
    rst         = 1'b0;
    tick(3);

    // Basic scan from an IDLE load
    rst    = 1'b1;
    bus.en = 1'b0;
    do_load(16'h1234);
    tick();
    bus.en = 1'b1;
    tick(45);

    // Tear-free update mid-frame
    run_until(B + S + 1);
    do_load(16'hABCD);
    tick(40);

    // Boundary load overrides pending shadow
    run_until(7);
    do_load(16'h9999);
    run_until(F - 1);
    do_load(16'h5555);
    tick(25);

    // Disable during digit-2 drive, then reset mid-slot
    run_until(2 * S + B + 1);
    bus.en = 1'b0;
    tick(10);
    bus.en = 1'b1;
    tick(13);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick(5);

    // Leading-zero patterns
    do_load(16'h0070);
    tick(25);
    do_load(16'h0000);
    tick(25);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.en      = ($urandom_range(0, 9) != 0);
      bus.load    = ($urandom_range(0, 9) == 0);
      bus.data_in = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.data_in[15:8] = 8'h00;
      rst         = ($urandom_range(0, 199) != 0);
      tick();
      rst = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexed seven-segment scan controller for the multiplier result display.
- Shares one active-low segment bus among NUM_DIGITS common-anode digits.
- Each digit gets a fixed refresh slot, with a blanking dead-time between slots to suppress ghosting.
- New display values are double-buffered and only take effect at a frame boundary, so a frame never shows a mix of old and new digits.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- REFRESH_CNT, 80000, clk cycles each digit is driven per slot (>=1).
- BLANK_CYCLES, 2, clk cycles with all anodes off before each slot (>=0; 0 removes the BLANK state).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- en  input  1  scan enable.
- load  input  1  single-cycle strobe; captures data_in.
- data_in  input  4*NUM_DIGITS  hex nibbles; nibble i goes to digit i, digit NUM_DIGITS-1 is most significant.
- an  output  NUM_DIGITS  anode drives, active-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- frame_done  output  1  one-cycle pulse at the end of the last digit's slot.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0 at a rising edge):
  - state=IDLE, idx=0, cnt=0.
  - active=0, shadow=0, pending=0.
  - an=all 1, seg=7'h7F, frame_done=0, busy=0.
  - Reset mid-slot takes effect at that edge; outputs are all-off in the next cycle.
- Outputs are Moore: decoded from registered state, idx and active, with no extra pipeline stage.
- States: IDLE, BLANK, DRIVE.
  - IDLE: an all off. If en=1 at an edge, go to BLANK with idx=0, cnt=0 (or DRIVE if BLANK_CYCLES=0).
  - BLANK: an all off, seg=7'h7F. Stays BLANK_CYCLES cycles, then goes to DRIVE with cnt=0.
  - DRIVE: an[idx]=0, other anodes 1, seg=hex7(active[idx]). Stays REFRESH_CNT cycles.
- End of a DRIVE slot (cnt==REFRESH_CNT-1):
  - If idx<NUM_DIGITS-1: idx+1.
  - Else: idx wraps to 0, frame_done=1 for the next cycle, and if pending=1 then active<=shadow and pending<=0.
  - Then, if en=1, go to BLANK (or DRIVE if BLANK_CYCLES=0); if en=0, go to IDLE.
  - en=0 mid-slot never truncates the current slot.
- Load handling:
  - load in BLANK/DRIVE, not at a frame boundary: shadow<=data_in, pending<=1. A later load overwrites shadow (last write wins).
  - load in IDLE: active<=data_in directly, pending<=0.
  - load coincident with a frame-boundary edge: active<=data_in directly, pending<=0 (newest data wins over the older shadow).
- Counter widths: cnt is $clog2(max(REFRESH_CNT,BLANK_CYCLES)+1) bits; idx is $clog2(NUM_DIGITS) bits (minimum 1). No wrap beyond terminal count.
- hex7 decode (active-low):
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30
  - 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03
  - C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- Frame period = NUM_DIGITS*(BLANK_CYCLES+REFRESH_CNT) cycles.

Optional Feature:
- Macro: DISPLAY_LZ_BLANK_EN.
- Defined: during DRIVE, digit idx is blanked (seg=7'h7F, an[idx] stays 1) when idx>0 and active nibbles idx..NUM_DIGITS-1 are all zero. Digit 0 is never blanked; timing is unchanged.
- Undefined: all digits are always displayed, including leading zeros.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_CNT=4, BLANK_CYCLES=1, giving a 20-cycle frame.
- Reset: hold rst=0 for 3 cycles with en=1 -> an=4'hF, seg=7'h7F, busy=0, frame_done=0.
- Basic scan: load data_in=16'h1234 in IDLE, then en=1 -> per slot, 1 blank cycle then 4 cycles of:
  - an=4'b1110 with seg=7'h19 ("4")
  - then an=4'b1101 with seg=7'h30 ("3")
  - then an=4'b1011 with seg=7'h24 ("2")
  - then an=4'b0111 with seg=7'h79 ("1")
  - frame_done pulses every 20 cycles.
- Tear-free update: load 16'hABCD during digit-1 DRIVE of a 16'h1234 frame -> remaining slots still show 3,2,1; the next frame shows D,C,b,A; pending clears at the boundary.
- Simultaneous events: load 16'h5555 with shadow pending 16'h9999, exactly on the frame-boundary edge -> the next frame shows all "5" (7'h12) and the 9999 value is never displayed.
- Disable and reset mid-operation: en=0 during digit-2 DRIVE -> slot completes all 4 cycles, then IDLE (an=4'hF, busy=0). Separately, rst=0 mid-slot -> all-off on the next cycle.
- DISPLAY_LZ_BLANK_EN defined, data 16'h0070 -> digits 3 and 2 blanked, digit 1 shows "7" (7'h78), digit 0 shows "0" (7'h40). With data 16'h0000, only digit 0 is lit.
